// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with write-through bypass and pending-write scoreboard
module regfile_sb #(
  parameter int WORD_W = 32,
  parameter int NREGS = 32,
  parameter int NRD = 2,
  parameter int NWR = 2,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [NRD*AW-1:0]     rsel,
  output logic [NRD*WORD_W-1:0] rdat,
  output logic [NRD-1:0]        rbusy,
  input  logic [NWR-1:0]        wen,
  input  logic [NWR*AW-1:0]     wsel,
  input  logic [NWR*WORD_W-1:0] wdat,
  input  logic                  rsv_en,
  input  logic [AW-1:0]         rsv_sel,
  output logic                  rsv_ready,
  input  logic                  flush,
  output logic [NREGS-1:0]      busy_vec
);
  logic [WORD_W-1:0] regs [NREGS];
  logic [NREGS-1:0] busy, clr, busy_nxt;
  logic [NWR-1:0] wv;
  always_comb begin
    wv = '0;
    clr = '0;
    for (int j = 0; j < NWR; j++) begin
      wv[j] = wen[j] && wsel[j*AW +: AW] != '0;
      if (wv[j]) clr[wsel[j*AW +: AW]] = 1'b1;
    end
  end
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] r;
    logic [WORD_W-1:0] d;
    assign r = rsel[i*AW +: AW];
    always_comb begin
      d = r == '0 ? '0 : regs[r];
      for (int j = 0; j < NWR; j++)
        if (wv[j] && wsel[j*AW +: AW] == r) d = wdat[j*WORD_W +: WORD_W];
    end
    assign rdat[i*WORD_W +: WORD_W] = d;
    assign rbusy[i] = busy[r] & ~clr[r];
  end
  assign rsv_ready = rsv_sel == '0 || !busy[rsv_sel] || clr[rsv_sel];
  always_comb begin
    busy_nxt = flush ? '0 : busy & ~clr;
    if (rsv_en && rsv_ready && !flush && rsv_sel != '0) busy_nxt[rsv_sel] = 1'b1;
  end
  always_ff @(posedge clk)
    if (!nrst) busy <= '0;
    else busy <= busy_nxt;
  always_ff @(posedge clk)
    if (!nrst) for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    else for (int j = 0; j < NWR; j++)
      if (wv[j]) regs[wsel[j*AW +: AW]] <= wdat[j*WORD_W +: WORD_W];
  assign busy_vec = busy;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed stimulus, per-cycle comparison against an array-based reference model
module tb_regfile_sb;
  localparam int AW = 5;
  localparam int W = 32;
  logic clk = 1'b0, nrst = 1'b0;
  logic [2*AW-1:0] rsel = '0;
  logic [2*W-1:0] rdat;
  logic [1:0] rbusy;
  logic [1:0] wen = '0;
  logic [2*AW-1:0] wsel = '0;
  logic [2*W-1:0] wdat = '0;
  logic rsv_en = 1'b0, rsv_ready, flush = 1'b0;
  logic [AW-1:0] rsv_sel = '0;
  logic [31:0] busy_vec;
  int n_pass = 0, n_tot = 0;
  logic [31:0] m_regs [32];
  logic [31:0] m_busy = '0;
  bit seeded = 0;

  regfile_sb dut (.clk(clk), .nrst(nrst), .rsel(rsel), .rdat(rdat), .rbusy(rbusy),
    .wen(wen), .wsel(wsel), .wdat(wdat), .rsv_en(rsv_en), .rsv_sel(rsv_sel),
    .rsv_ready(rsv_ready), .flush(flush), .busy_vec(busy_vec));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_tot++;
    if (a !== e) $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    else n_pass++;
  endtask

  function automatic int ws(input int j);
    return int'(wsel[j*AW +: AW]);
  endfunction

  function automatic bit clearing(input int r);
    for (int j = 0; j < 2; j++) if (wen[j] && r != 0 && ws(j) == r) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] exp_rd(input int i);
    int r = int'(rsel[i*AW +: AW]);
    logic [31:0] v;
    if (r == 0) return 32'h0;
    v = m_regs[r];
    for (int j = 0; j < 2; j++) if (wen[j] && ws(j) == r) v = wdat[j*W +: W];
    return v;
  endfunction

  function automatic bit exp_ready();
    int s = int'(rsv_sel);
    return s == 0 || !m_busy[s] || clearing(s);
  endfunction

  initial for (int r = 0; r < 32; r++) m_regs[r] = '0;

  always @(posedge clk) begin
    logic [31:0] nb;
    if (!nrst) begin
      for (int r = 0; r < 32; r++) m_regs[r] = '0;
      m_busy = '0;
      seeded = 1;
    end else begin
      nb = m_busy;
      for (int r = 1; r < 32; r++) if (clearing(r)) nb[r] = 1'b0;
      if (flush) nb = '0;
      else if (rsv_en && exp_ready() && rsv_sel != '0) nb[rsv_sel] = 1'b1;
      for (int j = 0; j < 2; j++) if (wen[j] && ws(j) != 0) m_regs[ws(j)] = wdat[j*W +: W];
      m_busy = nb;
    end
  end

  always @(negedge clk) if (seeded) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rdat%0d", i), {32'h0, rdat[i*W +: W]}, {32'h0, exp_rd(i)});
      chk($sformatf("rbusy%0d", i), {63'h0, rbusy[i]},
          {63'h0, m_busy[rsel[i*AW +: AW]] & ~clearing(int'(rsel[i*AW +: AW]))});
    end
    chk("rsv_ready", {63'h0, rsv_ready}, {63'h0, exp_ready()});
    chk("busy_vec", {32'h0, busy_vec}, {32'h0, m_busy});
  end

  task automatic tick;
    @(posedge clk);
    #1;
    wen = '0; wsel = '0; wdat = '0; rsel = '0;
    rsv_en = 1'b0; rsv_sel = '0; flush = 1'b0;
  endtask

  task automatic wr(input int j, input int s, input logic [31:0] d);
    wen[j] = 1'b1;
    wsel[j*AW +: AW] = AW'(s);
    wdat[j*W +: W] = d;
  endtask

  task automatic rd(input int i, input int s);
    rsel[i*AW +: AW] = AW'(s);
  endtask

  task automatic rsv(input int s);
    rsv_en = 1'b1;
    rsv_sel = AW'(s);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    tick; tick;
    nrst = 1'b1;
    tick; rd(1, 5); rd(0, 0); rsv_sel = 5'd5; #2;
    chk("reset_rdat", {32'h0, rdat}, 64'h0);
    chk("reset_rbusy", {62'h0, rbusy}, 64'h0);
    chk("reset_busy_vec", {32'h0, busy_vec}, 64'h0);
    chk("reset_ready", {63'h0, rsv_ready}, 64'h1);
    tick; wr(0, 3, 32'hDEADBEEF); rd(0, 3); #2;
    chk("bypass", {32'h0, rdat[31:0]}, 64'hDEADBEEF);
    tick; rd(0, 3); #2;
    chk("stored", {32'h0, rdat[31:0]}, 64'hDEADBEEF);
    tick; wr(0, 0, 32'hDEADBEEF); rd(0, 0); rd(1, 0); #2;
    chk("r0_bypass", {32'h0, rdat[31:0]}, 64'h0);
    tick; rd(0, 0); #2;
    chk("r0_stored", {32'h0, rdat[31:0]}, 64'h0);
    tick; wr(0, 7, 32'h1111); wr(1, 7, 32'h2222); rd(0, 7); #2;
    chk("prio_bypass", {32'h0, rdat[31:0]}, 64'h2222);
    tick; rd(1, 7); #2;
    chk("prio_stored", {32'h0, rdat[63:32]}, 64'h2222);
    tick; rsv(4); #2;
    chk("rsv4_ready", {63'h0, rsv_ready}, 64'h1);
    tick; rsv(4); rd(0, 4); #2;
    chk("rsv4_busy", {63'h0, busy_vec[4]}, 64'h1);
    chk("waw_stall", {63'h0, rsv_ready}, 64'h0);
    chk("rbusy4", {63'h0, rbusy[0]}, 64'h1);
    tick; wr(1, 4, 32'hAA); rsv(4); rd(0, 4); #2;
    chk("clr_rsv_ready", {63'h0, rsv_ready}, 64'h1);
    chk("clr_rbusy", {63'h0, rbusy[0]}, 64'h0);
    chk("clr_bypass", {32'h0, rdat[31:0]}, 64'hAA);
    tick; wr(0, 4, 32'hBB); #2;
    chk("set_wins", {63'h0, busy_vec[4]}, 64'h1);
    tick; #2;
    chk("write_clears", {63'h0, busy_vec[4]}, 64'h0);
    tick; rsv(1);
    tick; rsv(2);
    tick; rsv(9);
    tick; flush = 1'b1; rsv(10); wr(0, 2, 32'h55); #2;
    chk("pre_flush", {32'h0, busy_vec}, 64'h206);
    tick; rd(0, 2); rd(1, 10); #2;
    chk("flushed", {32'h0, busy_vec}, 64'h0);
    chk("flush_write", {32'h0, rdat[31:0]}, 64'h55);
    tick; rsv(6); wr(0, 8, 32'h1234);
    tick; #2;
    chk("pre_reset", {32'h0, busy_vec}, 64'h40);
    nrst = 1'b0; wr(0, 9, 32'h99);
    tick; nrst = 1'b1; rd(0, 8); rd(1, 9); #2;
    chk("post_reset_rdat", {32'h0, rdat[31:0]}, 64'h0);
    chk("post_reset_drop", {32'h0, rdat[63:32]}, 64'h0);
    chk("post_reset_busy", {32'h0, busy_vec}, 64'h0);
    tick; tick;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port register file with same-cycle write-through bypass and a per-register pending-write scoreboard. It is the successor to the single-write, two-read CPU register file. It sits in the decode stage of the pipelined datapath, where it supplies operands and hazard flags to the hazard unit. Writeback ports retire results, and an issue-side reservation port marks destinations that have an in-flight producer.

## Interface
Parameters:
- WORD_W, 32, data word width
- NREGS, 32, number of registers (power of two, ≥2); AW = $clog2(NREGS) is derived, not overridable
- NRD, 2, read port count
- NWR, 2, write port count; a higher port index is younger and has priority

Ports (slice k of a packed vector is [k*W +: W]):
- clk  in  1  clock; all state updates on the rising edge
- nrst  in  1  reset, synchronous, active-low
- rsel  in  NRD*AW  read register selects
- rdat  out  NRD*WORD_W  read data, combinational
- rbusy  out  NRD  pending-write flag for each read register, combinational
- wen  in  NWR  write enables
- wsel  in  NWR*AW  write register selects
- wdat  in  NWR*WORD_W  write data
- rsv_en  in  1  reservation request
- rsv_sel  in  AW  register to reserve
- rsv_ready  out  1  reservation can be accepted this cycle
- flush  in  1  clear all busy bits
- busy_vec  out  NREGS  scoreboard state (registered)

## Operation
- State consists of regs[NREGS][WORD_W] and busy[NREGS].
- Register 0:
  - Reads of register 0 return 0.
  - Writes to register 0 are dropped.
  - busy[0] is constant 0.
- Write: for each j with wen[j] and wsel[j]≠0, regs[wsel[j]] takes wdat[j] at the clock edge. If several ports hit the same register, the highest j wins.
- Read bypass: for each read port i:
  - If any port j has wen[j] and wsel[j]==rsel[i]≠0, rdat[i] = wdat of the highest such j.
  - Otherwise rdat[i] = regs[rsel[i]].
- Clear: each valid write (wen[j], wsel[j]≠0) clears busy[wsel[j]].
- rbusy[i] = busy[rsel[i]] & ~(same-cycle clear of rsel[i]). This matches the bypassed data.
- rsv_ready = 1 when any of the following holds:
  - rsv_sel==0;
  - busy[rsv_sel]==0;
  - busy[rsv_sel] is being cleared this cycle.
- A register already busy and not being cleared is a WAW stall: rsv_ready=0.
- Reservation is accepted when rsv_en & rsv_ready & ~flush and rsv_sel≠0. An accepted reservation sets busy[rsv_sel].
- When a set and a clear hit the same register in one cycle, the set wins. The write retires the old producer and the reservation is the new producer.
- rsv_en with rsv_ready=0 has no effect. The requester holds rsv_en/rsv_sel until accepted.
- flush=1 makes next busy all 0, and any reservation that cycle is discarded. Writes in the same cycle still update regs.
- Reset (nrst=0 at an edge):
  - All regs become 0 and all busy bits become 0.
  - Writes, reservations and flush in that cycle are ignored.

## Timing
- Read data and rbusy have zero-cycle latency (combinational from rsel, wen, wsel, wdat and state).
- A write is visible:
  - through bypass in the same cycle;
  - from regs on the cycle after the edge.
- A reservation accepted at edge N shows busy_vec=1 and rbusy=1 from cycle N+1.
- rsv_ready depends combinationally on rsv_sel, wen and wsel. The requester must not make rsv_en depend on rsv_ready combinationally.
- Reset values:
  - rdat reflects regs = 0;
  - rbusy = 0;
  - busy_vec = 0;
  - rsv_ready = 1.
- Reset asserted mid-operation takes effect at the next edge and discards all pending state, including outstanding reservations.
- The only clock domain is clk.

## Test plan
- Reset then read: with NRD=2, rsel={5,0} → rdat all 0, rbusy=0, busy_vec=0, rsv_ready=1.
- Write/bypass:
  - wen[0]=1, wsel[0]=3, wdat[0]=0xDEADBEEF, rsel[0]=3 → rdat[0]=0xDEADBEEF in the same cycle, and from regs on the next cycle.
  - Same stimulus with wsel[0]=0 → reads of register 0 stay 0.
- Write priority: wen=2'b11, wsel={7,7}, wdat={0x2222,0x1111} → same-cycle rdat for register 7 = 0x2222, and regs[7]=0x2222 afterwards.
- Scoreboard:
  - Reserve register 4 → busy_vec[4]=1 the next cycle.
  - A second reserve of 4 → rsv_ready=0, no change.
  - Write to 4 with a simultaneous reserve of 4 → rsv_ready=1, rbusy for 4 = 0 that cycle, busy_vec[4] stays 1.
  - Write to 4 alone → busy_vec[4]=0.
- Flush:
  - Reserve registers 1, 2, 9, then flush=1 with rsv_en on register 10 → busy_vec=0 and register 10 not reserved.
  - A concurrent write to 2 of 0x55 → regs[2]=0x55.
- Reset mid-operation: busy set and regs nonzero, nrst=0 for one edge → all regs 0, busy_vec 0. A write asserted during that edge is not stored.
